// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// mul_seq_ctrl: iterative unsigned shift-add multiplier controller driving one external adder.
// Rev 1.0
module mul_seq_ctrl #(
  parameter int Width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [Width-1:0]     opA,
  input  logic [Width-1:0]     opB,
  output logic                 inReady,
  output logic [Width-1:0]     addA,
  output logic [Width-1:0]     addB,
  input  logic [Width-1:0]     addSum,
  input  logic                 addCout,
  output logic [2*Width-1:0]   product,
  output logic                 outValid,
  input  logic                 outReady
);

  localparam int CW = $clog2(Width) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [Width-1:0]     r_mcand;
  logic [Width-1:0]     r_accHi;
  logic [Width-1:0]     r_accLo;
  logic [CW-1:0]        r_count;
  logic [2*Width-1:0]   r_product;
  logic                 r_outValid;
  logic                 r_inReady;

  logic                 w_run;
  logic [Width-1:0]     w_nextHi;
  logic [Width-1:0]     w_nextLo;

  // Adder operands are forced to zero outside RUN so the shared adder stays quiet.
  assign w_run    = (r_state == S_RUN);
  assign addA     = w_run ? r_accHi : '0;
  assign addB     = (w_run && r_accLo[0]) ? r_mcand : '0;
  assign w_nextHi = {addCout, addSum[Width-1:1]};
  assign w_nextLo = {addSum[0], r_accLo[Width-1:1]};

  assign inReady  = r_inReady;
  assign outValid = r_outValid;
  assign product  = r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_accHi    <= '0;
      r_accLo    <= '0;
      r_count    <= '0;
      r_product  <= '0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand   <= opA;
            r_accLo   <= opB;
            r_accHi   <= '0;
            r_count   <= CW'(Width);
            r_inReady <= 1'b0;
            if (opA == '0 || opB == '0) begin
              r_product  <= '0;
              r_outValid <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_accHi <= w_nextHi;
          r_accLo <= w_nextLo;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_product  <= {w_nextHi, w_nextLo};
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (outReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
